sct_arbiter: RTL and testbench
==============================

SCT_ARBITER -- requirements
Module: sct_arbiter

Interface
REQ-001 Parameter NREQ, default 5, number of requesters sharing the resource (legal 2..8).
REQ-002 Parameter TMAX, default 15, maximum grant hold time in cycles (legal 1..255).
REQ-003 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 prst  input  1  reset, synchronous and active-high.
REQ-005 pe  input  1  arbiter enable; low blocks new grants and revokes any active grant.
REQ-006 preq  input  NREQ  per-requester request, level-sensitive.
REQ-007 plock  input  1  suppresses the timeout of the current grant while high.
REQ-008 pgnt  output  NREQ  one-hot grant vector, registered.
REQ-009 pgid  output  3  binary index of the granted requester; 0 when no grant.
REQ-010 pbusy  output  1  high while in GRANT state.
REQ-011 ptmo  output  1  one-cycle pulse on timeout revocation.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-013 IDLE: when pe=1 and preq is nonzero, the FSM SHALL go to GRANT and assert pgnt for the winner on the next edge (one-cycle grant latency).
REQ-014 The winner SHALL be the first asserted request at or after pointer rr, searching upward with wrap from NREQ-1 to 0.
REQ-015 On entering GRANT, rr SHALL become winner+1, wrapping from NREQ-1 to 0.
REQ-016 GRANT: an 8-bit hold counter SHALL clear on entry and increment each cycle the grant is held, saturating at 255.
REQ-017 GRANT SHALL exit to GAP on whichever of these occurs first: the granted preq bit drops, pe drops, or the counter reaches TMAX-1 with plock=0.
REQ-018 On a timeout exit, ptmo SHALL pulse high for exactly the first GAP cycle.
REQ-019 If release and timeout conditions are true in the same cycle, the exit SHALL count as a release, with no ptmo pulse.
REQ-020 With plock=1 the grant SHALL persist past TMAX; when plock drops with the counter at or above TMAX-1, the timeout SHALL apply on that cycle.
REQ-021 GAP SHALL last exactly one cycle with pgnt=0, then go to IDLE, so no requester is granted on back-to-back cycles.
REQ-022 Requests from other requesters during GRANT SHALL have no effect on the current grant.
REQ-023 pgnt SHALL never have more than one bit set, and pgid SHALL always match pgnt.
REQ-024 Request bits at index NREQ or above SHALL be ignored, and pgid SHALL never reach NREQ.

Reset
REQ-025 prst=1 SHALL force IDLE, rr=0, counter=0, pgnt=0, pgid=0, pbusy=0 and ptmo=0 on the next edge.
REQ-026 Reset SHALL take priority over every other input, including during GRANT or GAP; the active grant SHALL drop with no ptmo pulse.
REQ-027 In the first cycle after prst falls, the arbiter SHALL accept requests as in IDLE.

Verification
REQ-028 Reset, pe=1, preq=5'b10100 at cycle 0 -> pgnt=5'b00100, pgid=2 at cycle 1; rr=3.
REQ-029 All five requesters held high continuously, no plock -> grants in order 0,1,2,3,4,0, each grant lasting TMAX cycles followed by one GAP cycle, with ptmo pulsing in each GAP.
REQ-030 Requester 1 granted, preq[1] dropped after 3 cycles -> pgnt=0 on the next edge, ptmo=0, IDLE one cycle later.
REQ-031 Requester 3 granted, plock=1 for 40 cycles then 0 -> grant held 40+ cycles, then GAP with ptmo=1 for one cycle.
REQ-032 pe dropped mid-grant -> GAP on the next edge, no ptmo; with pe still 0, no new grant despite pending requests.
REQ-033 prst asserted during GRANT with pgid=4 -> all outputs 0 on the next edge; after release, preq=5'b11111 -> grant to requester 0.

Source files
------------

// File: rtl/sct_arbiter.sv
// sct_arbiter: round-robin arbiter granting one of NREQ requesters a shared
// resource. A grant is held while its request stays high, is revoked on
// enable loss or after TMAX cycles (unless locked), and is always followed
// by a one-cycle gap so no requester is granted on back-to-back cycles.
module sct_arbiter #(
    parameter int NREQ = 5,
    parameter int TMAX = 15
) (
    input  logic            pclk,
    input  logic            prst,
    input  logic            pe,
    input  logic [NREQ-1:0] preq,
    input  logic            plock,
    output logic [NREQ-1:0] pgnt,
    output logic [2:0]      pgid,
    output logic            pbusy,
    output logic            ptmo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);
    localparam logic [7:0] TMO_CNT  = 8'(TMAX - 1);
    localparam logic [7:0] CNT_MAX  = 8'd255;

    state_t            state_r;
    logic [2:0]        rr_r;
    logic [7:0]        cnt_r;
    logic [NREQ-1:0]   pgnt_r;
    logic [2:0]        pgid_r;
    logic              pbusy_r;
    logic              ptmo_r;

    int                best_dist_s;
    int                dist_s;
    logic [2:0]        win_idx_s;
    logic              win_found_s;
    logic [2:0]        rr_next_s;
    logic              req_held_s;
    logic              release_s;
    logic              timeout_s;
    logic [7:0]        cnt_inc_s;

    // One-hot decode of a requester index into a grant vector.
    function automatic logic [NREQ-1:0] to_onehot(input logic [2:0] idx);
        logic [NREQ-1:0] oh;
        for (int j = 0; j < NREQ; j++) begin
            oh[j] = (3'(j) == idx);
        end
        return oh;
    endfunction

    assign pgnt  = pgnt_r;
    assign pgid  = pgid_r;
    assign pbusy = pbusy_r;
    assign ptmo  = ptmo_r;

    // Round-robin search: pick the asserted request closest upward from rr_r.
    always_comb begin
        best_dist_s = NREQ;
        dist_s      = 0;
        win_idx_s   = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (j >= int'(rr_r)) begin
                dist_s = j - int'(rr_r);
            end else begin
                dist_s = j + NREQ - int'(rr_r);
            end
            if (preq[j] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                win_idx_s   = 3'(j);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        win_found_s = (best_dist_s < NREQ);
    end

    // Exit conditions for an active grant and next-value helpers.
    always_comb begin
        req_held_s = |(preq & pgnt_r);
        release_s  = !pe || !req_held_s;
        timeout_s  = (cnt_r >= TMO_CNT) && !plock;
        if (win_idx_s == LAST_IDX) begin
            rr_next_s = 3'd0;
        end else begin
            rr_next_s = win_idx_s + 3'd1;
        end
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 8'd1;
        end
    end

    // Arbiter FSM with registered grant, index, busy and timeout outputs.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_r <= ST_IDLE;
            rr_r    <= 3'd0;
            cnt_r   <= 8'd0;
            pgnt_r  <= {NREQ{1'b0}};
            pgid_r  <= 3'd0;
            pbusy_r <= 1'b0;
            ptmo_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ptmo_r <= 1'b0;
                    if (pe && win_found_s) begin
                        state_r <= ST_GRANT;
                        rr_r    <= rr_next_s;
                        cnt_r   <= 8'd0;
                        pgnt_r  <= to_onehot(win_idx_s);
                        pgid_r  <= win_idx_s;
                        pbusy_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        pgnt_r  <= {NREQ{1'b0}};
                        pgid_r  <= 3'd0;
                        pbusy_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s || timeout_s) begin
                        // Release wins over a simultaneous timeout: no pulse.
                        state_r <= ST_GAP;
                        pgnt_r  <= {NREQ{1'b0}};
                        pgid_r  <= 3'd0;
                        pbusy_r <= 1'b0;
                        ptmo_r  <= timeout_s && !release_s;
                    end else begin
                        state_r <= ST_GRANT;
                        cnt_r   <= cnt_inc_s;
                        ptmo_r  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                    pgnt_r  <= {NREQ{1'b0}};
                    pgid_r  <= 3'd0;
                    pbusy_r <= 1'b0;
                    ptmo_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    pgnt_r  <= {NREQ{1'b0}};
                    pgid_r  <= 3'd0;
                    pbusy_r <= 1'b0;
                    ptmo_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sct_arbiter.sv
// Testbench for sct_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the arbitration rules.
module tb_sct_arbiter;

    localparam int NREQ = 5;
    localparam int TMAX = 15;

    logic            pclk = 1'b0;
    logic            prst;
    logic            pe;
    logic [NREQ-1:0] preq;
    logic            plock;
    logic [NREQ-1:0] pgnt;
    logic [2:0]      pgid;
    logic            pbusy;
    logic            ptmo;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: who owns the resource, how long it has been visible,
    // whether we are in the mandatory gap, next search start, timeout pulse.
    int m_owner = -1;
    int m_vis   = 0;
    int m_rr    = 0;
    bit m_gap   = 1'b0;
    bit m_tmo   = 1'b0;

    sct_arbiter #(.NREQ(NREQ), .TMAX(TMAX)) dut (
        .pclk  (pclk),
        .prst  (prst),
        .pe    (pe),
        .preq  (preq),
        .plock (plock),
        .pgnt  (pgnt),
        .pgid  (pgid),
        .pbusy (pbusy),
        .ptmo  (ptmo)
    );

    // Free-running clock.
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    endtask

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic model_update();
        bit rel;
        bit tmo;
        if (prst) begin
            m_owner = -1; m_vis = 0; m_rr = 0; m_gap = 1'b0; m_tmo = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0; m_tmo = 1'b0;
        end else if (m_owner >= 0) begin
            rel = !pe || !preq[m_owner];
            tmo = (m_vis >= TMAX) && !plock;
            m_tmo = 1'b0;
            if (rel || tmo) begin
                m_tmo   = tmo && !rel;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_vis++;
            end
        end else begin
            m_tmo = 1'b0;
            if (pe) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_rr + k) % NREQ;
                    if (m_owner < 0 && preq[c]) begin
                        m_owner = c;
                        m_vis   = 1;
                        m_rr    = (c + 1) % NREQ;
                    end
                end
            end
        end
    endtask

    // One clock: edge, model update, then compare all outputs 1 time unit later.
    task automatic step();
        @(posedge pclk);
        model_update();
        #1;
        chk("pgnt",  int'(pgnt),  (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("pgid",  int'(pgid),  (m_owner >= 0) ? m_owner : 0);
        chk("pbusy", int'(pbusy), (m_owner >= 0) ? 1 : 0);
        chk("ptmo",  int'(ptmo),  int'(m_tmo));
    endtask

    task automatic do_reset();
        prst = 1'b1;
        step();
        prst = 1'b0;
    endtask

    initial begin
        int len;
        int busy_cnt;
        prst = 1'b1; pe = 1'b0; preq = 5'b00000; plock = 1'b0;

        // Reset state.
        step();
        chk("rst_pgnt", int'(pgnt), 0);
        chk("rst_pgid", int'(pgid), 0);
        chk("rst_pbusy", int'(pbusy), 0);
        chk("rst_ptmo", int'(ptmo), 0);

        // First grant after reset goes to requester 2, leaving rr at 3.
        prst = 1'b0; pe = 1'b1; preq = 5'b10100;
        step();
        chk("first_pgnt", int'(pgnt), 4);
        chk("first_pgid", int'(pgid), 2);
        preq = 5'b00000;
        step();
        step();

        // All requesters held: rotation from 3, TMAX-cycle grants, ptmo per gap.
        preq = 5'b11111;
        step();
        chk("rr_after_first", int'(pgid), 3);
        for (int g = 0; g < 6; g++) begin
            chk("rot_id", int'(pgid), (3 + g) % 5);
            len = 1;
            for (int t = 0; t < 300; t++) begin
                step();
                if (!pbusy) break;
                len++;
            end
            chk("rot_len", len, TMAX);
            chk("rot_tmo", int'(ptmo), 1);
            step();
            step();
        end
        preq = 5'b00000;
        step();
        step();
        step();

        // Requester 1 releases after 3 cycles: no timeout pulse.
        do_reset();
        pe = 1'b1; preq = 5'b00010;
        step();
        chk("rel_pgid", int'(pgid), 1);
        step();
        step();
        preq = 5'b00000;
        step();
        chk("rel_pgnt", int'(pgnt), 0);
        chk("rel_ptmo", int'(ptmo), 0);
        step();

        // Locked grant to requester 3 outlives TMAX, times out when unlocked.
        do_reset();
        preq = 5'b01000; plock = 1'b1;
        step();
        chk("lock_pgid", int'(pgid), 3);
        busy_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (pbusy) busy_cnt++;
        end
        chk("lock_busy", busy_cnt, 40);
        plock = 1'b0;
        step();
        chk("lock_ptmo", int'(ptmo), 1);
        chk("lock_pbusy", int'(pbusy), 0);
        preq = 5'b00000;
        step();
        chk("lock_pulse_end", int'(ptmo), 0);

        // Enable drop revokes the grant and blocks new ones.
        do_reset();
        preq = 5'b00001;
        step();
        step();
        pe = 1'b0;
        step();
        chk("pe_pbusy", int'(pbusy), 0);
        chk("pe_ptmo", int'(ptmo), 0);
        preq = 5'b11111;
        for (int t = 0; t < 5; t++) step();
        chk("pe_blocked", int'(pgnt), 0);

        // Reset during a grant to requester 4, then grant to 0.
        pe = 1'b1; preq = 5'b10000;
        do_reset();
        step();
        chk("rg_pgid", int'(pgid), 4);
        step();
        prst = 1'b1;
        step();
        chk("rg_pgnt", int'(pgnt), 0);
        chk("rg_pbusy", int'(pbusy), 0);
        chk("rg_ptmo", int'(ptmo), 0);
        prst = 1'b0; preq = 5'b11111;
        step();
        chk("rg_after", int'(pgid), 0);

        // Randomized traffic.
        for (int t = 0; t < 4000; t++) begin
            prst = ($urandom_range(0, 199) == 0);
            if (pe) begin
                if ($urandom_range(0, 39) == 0) pe = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) pe = 1'b1;
            end
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 11) == 0) preq[b] = ~preq[b];
            end
            if ($urandom_range(0, 24) == 0) plock = ~plock;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
